// File: rtl/placar_display.sv
// Dual 7-bit score to 3-digit BCD converter (shift-add-3) driving a 6-digit,
// time-multiplexed, active-low seven-segment display with leading-zero blanking.
module placar_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clock,
    input  logic       clr,
    input  logic [6:0] somaTime1,
    input  logic [6:0] somaTime2,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       bcd_valid
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} convStateT;

    convStateT   state, nextState;
    logic        startPending;
    logic [6:0]  shadow1, shadow2;
    logic [6:0]  binSh1, binSh2;
    logic [11:0] bcd1, bcd2;
    logic [11:0] disp1, disp2;
    logic [2:0]  bitCnt;
    logic [PW-1:0] prescaler;
    logic [2:0]  digitIdx, nextIdx;
    logic        scanWrap;
    logic [6:0]  nextSeg;

    function automatic logic [11:0] dabble(input logic [11:0] b, input logic inBit);
        logic [11:0] a;
        a = b;
        for (int unsigned i = 0; i < 3; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return {a[10:0], inBit};
    endfunction

    function automatic logic [6:0] segCode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (startPending || somaTime1 != shadow1 || somaTime2 != shadow2)
                       nextState = LOAD;
            LOAD:  nextState = SHIFT;
            SHIFT: if (bitCnt == 3'd7) nextState = DONE;
            DONE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath acts on the edge that enters each state, so DONE's display
    // write lands on edge 9 of a conversion that starts with LOAD at edge 1.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            startPending <= 1'b1;
            shadow1      <= '0;
            shadow2      <= '0;
            binSh1       <= '0;
            binSh2       <= '0;
            bcd1         <= '0;
            bcd2         <= '0;
            disp1        <= '0;
            disp2        <= '0;
            bitCnt       <= '0;
            bcd_valid    <= 1'b0;
        end else begin
            case (nextState)
                LOAD: begin
                    startPending <= 1'b0;
                    shadow1      <= somaTime1;
                    shadow2      <= somaTime2;
                    binSh1       <= somaTime1;
                    binSh2       <= somaTime2;
                    bcd1         <= '0;
                    bcd2         <= '0;
                    bitCnt       <= '0;
                end
                SHIFT: begin
                    bcd1   <= dabble(bcd1, binSh1[6]);
                    bcd2   <= dabble(bcd2, binSh2[6]);
                    binSh1 <= {binSh1[5:0], 1'b0};
                    binSh2 <= {binSh2[5:0], 1'b0};
                    bitCnt <= bitCnt + 3'd1;
                end
                DONE: begin
                    disp1     <= bcd1;
                    disp2     <= bcd2;
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign scanWrap = (prescaler == PW'(SCAN_DIV - 1));
    assign nextIdx  = (digitIdx == 3'd5) ? 3'd0 : digitIdx + 3'd1;

    always_comb begin
        logic [11:0] team;
        logic [3:0]  hund, tens, unit;
        team    = (nextIdx >= 3'd3) ? disp1 : disp2;
        hund    = team[11:8];
        tens    = team[7:4];
        unit    = team[3:0];
        nextSeg = segCode(unit);
        case (nextIdx)
            3'd5, 3'd2: nextSeg = (hund == 4'd0) ? 7'b1111111 : segCode(hund);
            3'd4, 3'd1: nextSeg = (hund == 4'd0 && tens == 4'd0) ? 7'b1111111 : segCode(tens);
            default:    nextSeg = segCode(unit);
        endcase
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            prescaler <= '0;
            digitIdx  <= '0;
            an        <= 6'b111110;
            seg       <= 7'b0000001;
        end else if (scanWrap) begin
            prescaler <= '0;
            digitIdx  <= nextIdx;
            an        <= ~(6'b000001 << nextIdx);
            seg       <= nextSeg;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

endmodule

// File: doc/placar_display.md
PLACAR_DISPLAY -- requirements
Module: placar_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit stays enabled (legal ≥2).
REQ-002 The block SHALL have port clock  input  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port clr  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port somaTime1  input  7  team-1 score, unsigned binary 0..127.
REQ-005 The block SHALL have port somaTime2  input  7  team-2 score, unsigned binary 0..127.
REQ-006 The block SHALL have port seg  output  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-low.
REQ-007 The block SHALL have port an  output  6  digit enables, active-low, exactly one bit low at all times.
REQ-008 The block SHALL have port bcd_valid  output  1  high once the display registers hold a completed conversion.

Function
REQ-009 The block SHALL be a single-clock design; clr low SHALL force reset state immediately, without waiting for a clock edge.
REQ-010 The converter FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-011 LOAD (1 cycle) SHALL capture both score inputs into shadow registers and clear both BCD accumulators.
REQ-012 SHIFT SHALL last exactly 7 cycles; each cycle SHALL add 3 to every BCD nibble ≥5, then shift one binary bit MSB-first into each accumulator; both teams SHALL convert in parallel.
REQ-013 DONE (1 cycle) SHALL write both 3-digit BCD results (hundreds, tens, units) into the display registers, set bcd_valid, then go to IDLE.
REQ-014 IDLE SHALL go to LOAD whenever somaTime1 or somaTime2 differs from its shadow register; otherwise IDLE SHALL hold.
REQ-015 Input changes during LOAD/SHIFT/DONE SHALL be ignored by the running conversion; the mismatch SHALL be detected on return to IDLE, starting a new conversion.
REQ-016 Display registers SHALL change only in DONE; seg/an SHALL never show partial conversion values.
REQ-017 The first LOAD after reset SHALL occur on the first rising edge after clr deasserts, regardless of input values.
REQ-018 Conversion latency SHALL be 9 cycles: LOAD at edge 1, SHIFT at edges 2..8, DONE at edge 9; new values SHALL be visible after edge 9.
REQ-019 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; on the wrap the digit index SHALL advance 0→1→...→5→0.
REQ-020 Digit index k SHALL drive an[k] low and all other an bits high.
REQ-021 Digit mapping SHALL be: index 5/4/3 = team-1 hundreds/tens/units, index 2/1/0 = team-2 hundreds/tens/units.
REQ-022 Segment codes (abcdefg, active-low) SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-023 Leading-zero blanking SHALL apply: hundreds digit 0 → seg=1111111; tens digit blanked only when hundreds and tens are both 0; units SHALL always be shown.
REQ-024 seg and an SHALL be registered outputs, updated together on the same edge as the digit index.
REQ-025 bcd_valid SHALL remain high after the first DONE until the next reset.

Reset
REQ-026 Reset SHALL set: FSM=IDLE with start-pending, shadow registers=0, display BCD=000/000, prescaler=0, digit index=0, an=111110, seg=0000001, bcd_valid=0.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion with no display-register write; after release, REQ-017 applies.

Verification
REQ-028 Release reset, somaTime1=0, somaTime2=0 -> an=111110, seg=0000001 immediately; bcd_valid rises after edge 9 after release.
REQ-029 somaTime1=127, somaTime2=5, SCAN_DIV=4 -> index5..0 seg = 1001111, 0010010, 0001111, 1111111, 1111111, 0100100.
REQ-030 somaTime1=10, somaTime2=100 -> team-1 shows blank,1,0; team-2 shows 1,0,0 (tens 0 not blanked).
REQ-031 somaTime1 changes 3→45 during the 3rd SHIFT cycle -> display shows 3 after first DONE, then 45 after a second 9-cycle conversion (≤18 cycles after the first LOAD).
REQ-032 SCAN_DIV=4 -> an steps 111110,111101,111011,110111,101111,011111,111110, one step every 4 cycles; exactly one bit low throughout.
REQ-033 clr pulsed low during SHIFT -> outputs take the REQ-026 values asynchronously and bcd_valid=0; the conversion restarts after release.
